// File: rtl/pkt_link_pkg.sv
// Shared packet-link definitions: framing bytes, receiver states and checksum helper.
package pkt_link_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] START_BYTE = 8'hAA;
    localparam logic [BYTE_W-1:0] END_BYTE   = 8'h55;

    typedef enum logic [2:0] {
        IDLE,
        TYPE,
        LEN,
        PAYLOAD,
        CSUM,
        END,
        HOLD
    } rx_state_t;

    // Running mod-256 checksum step
    function automatic logic [BYTE_W-1:0] pkt_csum(input logic [BYTE_W-1:0] acc,
                                                   input logic [BYTE_W-1:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/uart2pkt_receiver.sv
// Frame receiver: hunts for AA..55 frames in a byte stream, validates LEN/CSUM/END
// and presents good frames as one packed word; bad frames are dropped and counted.
module uart2pkt_receiver
    import pkt_link_pkg::*;
#(
    parameter int unsigned PD_LEN      = 2,
    parameter int unsigned PKTLEN      = PD_LEN + 5,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           i_data,
    input  logic                 i_valid,
    output logic                 i_ready,
    output logic [8*PKTLEN-1:0]  o_data,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic                 o_csum_err,
    output logic                 o_frame_err,
    output logic [15:0]          o_pkt_cnt,
    output logic [15:0]          o_err_cnt
);

    localparam int unsigned AW = 8 * (PKTLEN - 1);
    localparam int unsigned IW = $clog2(PKTLEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IW-1:0] LAST_PD_IDX = IW'(PD_LEN + 2);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    LEN_BYTE    = 8'(PKTLEN);

    rx_state_t       state_q;
    rx_state_t       state_nxt;
    logic [AW-1:0]   asm_q;
    logic [IW-1:0]   idx_q;
    logic [7:0]      accum_q;
    logic [TW-1:0]   tmo_q;

    logic accept;
    logic in_frame;
    logic tmo_hit;
    logic csum_err_c;
    logic frame_err_c;
    logic frame_ok_c;
    logic deliver_c;

    assign accept   = i_valid && i_ready;
    assign in_frame = (state_q == TYPE) || (state_q == LEN) || (state_q == PAYLOAD) ||
                      (state_q == CSUM) || (state_q == END);
    // A byte arriving on the last allowed cycle still counts as in time
    assign tmo_hit  = in_frame && !accept && (tmo_q == TMO_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; any error returns to IDLE having consumed the byte
    always_comb begin
        state_nxt = state_q;
        if (csum_err_c || frame_err_c) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept && (i_data == START_BYTE)) state_nxt = TYPE;
                TYPE:    if (accept) state_nxt = LEN;
                LEN:     if (accept) state_nxt = PAYLOAD;
                PAYLOAD: if (accept && (idx_q == LAST_PD_IDX)) state_nxt = CSUM;
                CSUM:    if (accept) state_nxt = END;
                END:     if (accept) state_nxt = HOLD;
                HOLD:    if (deliver_c) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Event decode from current state and accepted byte
    always_comb begin
        csum_err_c  = 1'b0;
        frame_err_c = 1'b0;
        frame_ok_c  = 1'b0;
        deliver_c   = 1'b0;
        if (tmo_hit) begin
            frame_err_c = 1'b1;
        end else if (accept) begin
            case (state_q)
                LEN:     if (i_data != LEN_BYTE) frame_err_c = 1'b1;
                CSUM:    if (i_data != accum_q) csum_err_c = 1'b1;
                END: begin
                    if (i_data == END_BYTE) frame_ok_c  = 1'b1;
                    else                    frame_err_c = 1'b1;
                end
                default: ;
            endcase
        end
        if ((state_q == HOLD) && o_ready) deliver_c = 1'b1;
    end

    // Datapath: assembly, checksum, timeout, outputs and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q       <= '0;
            idx_q       <= '0;
            accum_q     <= '0;
            tmo_q       <= '0;
            i_ready     <= 1'b1;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_csum_err  <= 1'b0;
            o_frame_err <= 1'b0;
            o_pkt_cnt   <= '0;
            o_err_cnt   <= '0;
        end else begin
            i_ready     <= (state_nxt != HOLD);
            o_csum_err  <= csum_err_c;
            o_frame_err <= frame_err_c;

            if (accept || !in_frame) tmo_q <= '0;
            else                     tmo_q <= tmo_q + TW'(1);

            if (accept) begin
                if (state_q == IDLE) begin
                    if (i_data == START_BYTE) begin
                        asm_q[7:0] <= i_data;
                        idx_q      <= IW'(1);
                        accum_q    <= '0;
                    end
                end else if (in_frame) begin
                    for (int k = 1; k < int'(PKTLEN) - 1; k++) begin
                        if (idx_q == IW'(k)) asm_q[8*k +: 8] <= i_data;
                    end
                    idx_q <= idx_q + IW'(1);
                    if ((state_q == TYPE) || (state_q == LEN) || (state_q == PAYLOAD)) begin
                        accum_q <= pkt_csum(accum_q, i_data);
                    end
                end
            end

            if (frame_ok_c) begin
                o_data  <= {i_data, asm_q};
                o_valid <= 1'b1;
            end

            if (deliver_c) begin
                o_valid <= 1'b0;
                if (o_pkt_cnt != 16'hFFFF) o_pkt_cnt <= o_pkt_cnt + 16'd1;
            end

            if ((csum_err_c || frame_err_c) && (o_err_cnt != 16'hFFFF)) begin
                o_err_cnt <= o_err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart2pkt_receiver.sv
// Directed bench for uart2pkt_receiver with PD_LEN=2 (7-byte frames) and a 50-cycle timeout.
module tb_uart2pkt_receiver;

    localparam int unsigned PD_LEN = 2;
    localparam int unsigned PKTLEN = PD_LEN + 5;
    localparam int unsigned TMO    = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        i_ready;
    logic [55:0] o_data;
    logic        o_valid;
    logic        o_ready;
    logic        o_csum_err;
    logic        o_frame_err;
    logic [15:0] o_pkt_cnt;
    logic [15:0] o_err_cnt;

    int checks = 0;
    int passed = 0;

    int n_csum = 0;
    int n_ferr = 0;
    int n_viol = 0;
    logic [55:0] got_q[$];

    localparam logic [55:0] FRAME1 = 56'h554E3412_0701AA;
    localparam logic [55:0] FRAME2 = 56'h550A0100_0702AA;
    localparam logic [55:0] FRAME3 = 56'h55150605_0703AA;

    uart2pkt_receiver #(
        .PD_LEN      (PD_LEN),
        .PKTLEN      (PKTLEN),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_csum_err  (o_csum_err),
        .o_frame_err (o_frame_err),
        .o_pkt_cnt   (o_pkt_cnt),
        .o_err_cnt   (o_err_cnt)
    );

    always #5 clk = ~clk;

    // Observer on the falling edge: pulse counts, delivered frames, ready/valid overlap
    always @(negedge clk) begin
        if (!rst) begin
            if (o_csum_err)  n_csum++;
            if (o_frame_err) n_ferr++;
            if (o_valid && i_ready) n_viol++;
            if (o_valid && o_ready) got_q.push_back(o_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        i_data  = b;
        i_valid = 1'b1;
        while (i_ready !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL send_stall: i_ready=%b after %0d cycles, required 1", i_ready, n);
        end
        tick(1);
        i_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [55:0] v, input int n);
        for (int k = 0; k < n; k++) send_byte(v[8*k +: 8]);
    endtask

    task automatic test_reset;
        rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; o_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        checks++; if (o_valid !== 1'b0) $display("FAIL rst_o_valid: got %b want 0", o_valid); else passed++;
        checks++; if (i_ready !== 1'b1) $display("FAIL rst_i_ready: got %b want 1", i_ready); else passed++;
        checks++; if (o_data !== 56'h0) $display("FAIL rst_o_data: got %h want 0", o_data); else passed++;
        checks++; if (o_pkt_cnt !== 16'd0 || o_err_cnt !== 16'd0)
            $display("FAIL rst_counters: got pkt=%h err=%h want 0/0", o_pkt_cnt, o_err_cnt); else passed++;
        checks++; if (o_csum_err !== 1'b0 || o_frame_err !== 1'b0)
            $display("FAIL rst_pulses: got csum=%b frame=%b want 0/0", o_csum_err, o_frame_err); else passed++;
    endtask

    task automatic test_good_frame;
        o_ready = 1'b1;
        send_bytes(FRAME1, 7);
        checks++; if (o_valid !== 1'b1) $display("FAIL good_latency: o_valid=%b want 1", o_valid); else passed++;
        checks++; if (o_data !== FRAME1) $display("FAIL good_data: got %h want %h", o_data, FRAME1); else passed++;
        tick(1);
        checks++; if (o_valid !== 1'b0) $display("FAIL good_release: o_valid=%b want 0", o_valid); else passed++;
        checks++; if (o_pkt_cnt !== 16'd1) $display("FAIL good_pkt_cnt: got %0d want 1", o_pkt_cnt); else passed++;
        checks++; if (got_q.size() != 1) $display("FAIL good_count: got %0d frames want 1", got_q.size());
        else if (got_q[0] !== FRAME1) $display("FAIL good_capture: got %h want %h", got_q[0], FRAME1);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int c0 = n_csum;
        int f0 = n_ferr;
        o_ready = 1'b0;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_bytes(FRAME1, 7);
        fork
            send_bytes(FRAME2, 7);
            begin
                tick(20);
                checks++; if (i_ready !== 1'b0) $display("FAIL b2b_hold_ready: i_ready=%b want 0", i_ready); else passed++;
                checks++; if (o_valid !== 1'b1 || o_data !== FRAME1)
                    $display("FAIL b2b_hold_data: valid=%b data=%h want 1/%h", o_valid, o_data, FRAME1); else passed++;
                o_ready = 1'b1;
            end
        join
        tick(3);
        checks++; if (got_q.size() != 3) $display("FAIL b2b_count: got %0d frames want 3", got_q.size());
        else if (got_q[1] !== FRAME1 || got_q[2] !== FRAME2)
            $display("FAIL b2b_order: got %h,%h want %h,%h", got_q[1], got_q[2], FRAME1, FRAME2);
        else passed++;
        checks++; if (o_pkt_cnt !== 16'd3) $display("FAIL b2b_pkt_cnt: got %0d want 3", o_pkt_cnt); else passed++;
        checks++; if (o_err_cnt !== 16'd0 || n_csum != c0 || n_ferr != f0)
            $display("FAIL b2b_no_err: err_cnt=%0d pulses=%0d want 0/0", o_err_cnt, (n_csum - c0) + (n_ferr - f0)); else passed++;
        checks++; if (n_viol != 0) $display("FAIL b2b_ready_in_hold: %0d cycles with i_ready during o_valid want 0", n_viol); else passed++;
    endtask

    task automatic test_bad_csum;
        int c0 = n_csum;
        send_bytes(56'h554F3412_0701AA, 6);
        checks++; if (o_csum_err !== 1'b1) $display("FAIL csum_pulse: o_csum_err=%b want 1", o_csum_err); else passed++;
        send_byte(8'h55);
        tick(3);
        checks++; if (n_csum - c0 != 1) $display("FAIL csum_pulse_cnt: got %0d want 1", n_csum - c0); else passed++;
        checks++; if (o_err_cnt !== 16'd1) $display("FAIL csum_err_cnt: got %0d want 1", o_err_cnt); else passed++;
        checks++; if (got_q.size() != 3 || o_valid !== 1'b0)
            $display("FAIL csum_dropped: frames=%0d valid=%b want 3/0", got_q.size(), o_valid); else passed++;
    endtask

    task automatic test_frame_err;
        int f0 = n_ferr;
        send_bytes(56'h00000000_0601AA, 3);
        checks++; if (o_frame_err !== 1'b1) $display("FAIL len_pulse: o_frame_err=%b want 1", o_frame_err); else passed++;
        send_bytes(56'h544E3412_0701AA, 7);
        checks++; if (o_frame_err !== 1'b1) $display("FAIL end_pulse: o_frame_err=%b want 1", o_frame_err); else passed++;
        // LEN byte of AA errors and must not itself open a new frame
        send_bytes(56'h00000000_AA01AA, 3);
        send_bytes(56'h554E3412_0701AA >> 8, 6);
        tick(3);
        checks++; if (n_ferr - f0 != 3) $display("FAIL ferr_pulse_cnt: got %0d want 3", n_ferr - f0); else passed++;
        checks++; if (o_err_cnt !== 16'd4) $display("FAIL ferr_err_cnt: got %0d want 4", o_err_cnt); else passed++;
        checks++; if (got_q.size() != 3 || o_pkt_cnt !== 16'd3)
            $display("FAIL ferr_no_frame: frames=%0d pkt_cnt=%0d want 3/3", got_q.size(), o_pkt_cnt); else passed++;
    endtask

    task automatic test_timeout;
        int f0 = n_ferr;
        int first = -1;
        send_bytes(FRAME1, 3);
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            if (o_frame_err === 1'b1 && first < 0) first = i;
        end
        checks++; if (first != int'(TMO)) $display("FAIL tmo_cycle: pulse at idle clk %0d want %0d", first, TMO); else passed++;
        checks++; if (n_ferr - f0 != 1) $display("FAIL tmo_pulse_cnt: got %0d want 1", n_ferr - f0); else passed++;
        checks++; if (o_err_cnt !== 16'd5) $display("FAIL tmo_err_cnt: got %0d want 5", o_err_cnt); else passed++;
        send_bytes(FRAME3, 7);
        tick(3);
        checks++; if (got_q.size() != 4) $display("FAIL tmo_recover_count: got %0d frames want 4", got_q.size());
        else if (got_q[3] !== FRAME3) $display("FAIL tmo_recover_data: got %h want %h", got_q[3], FRAME3);
        else passed++;
        checks++; if (o_pkt_cnt !== 16'd4) $display("FAIL tmo_pkt_cnt: got %0d want 4", o_pkt_cnt); else passed++;
    endtask

    task automatic test_reset_mid_frame;
        int c0 = n_csum;
        int f0 = n_ferr;
        send_bytes(FRAME1, 4);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        checks++; if (o_valid !== 1'b0 || i_ready !== 1'b1)
            $display("FAIL mrst_handshake: valid=%b ready=%b want 0/1", o_valid, i_ready); else passed++;
        checks++; if (o_pkt_cnt !== 16'd0 || o_err_cnt !== 16'd0)
            $display("FAIL mrst_counters: pkt=%0d err=%0d want 0/0", o_pkt_cnt, o_err_cnt); else passed++;
        checks++; if (n_csum != c0 || n_ferr != f0)
            $display("FAIL mrst_pulses: got %0d pulses want 0", (n_csum - c0) + (n_ferr - f0)); else passed++;
        send_bytes(FRAME1, 7);
        tick(3);
        checks++; if (got_q.size() != 5) $display("FAIL mrst_count: got %0d frames want 5", got_q.size());
        else if (got_q[4] !== FRAME1) $display("FAIL mrst_data: got %h want %h", got_q[4], FRAME1);
        else passed++;
        checks++; if (o_pkt_cnt !== 16'd1 || o_err_cnt !== 16'd0)
            $display("FAIL mrst_after: pkt=%0d err=%0d want 1/0", o_pkt_cnt, o_err_cnt); else passed++;
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_back_to_back;
        test_bad_csum;
        test_frame_err;
        test_timeout;
        test_reset_mid_frame;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end

endmodule
